// File: rtl/movement_arbiter.sv
`default_nettype none
// ============================================================================
// Module : movement_arbiter - checks piece moves against the board, freezes
//          landed pieces and collapses full rows; registered board read port.
// Rev    : 1.0
// ============================================================================
module movement_arbiter #(
    parameter int ROWS         = 20,
    parameter int COLS         = 10,
    parameter int GAMEOVER_ROW = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       movement_request,
    input  logic       movement_intent,
    input  logic [4:0] P1blk_v,
    input  logic [4:0] P2blk_v,
    input  logic [4:0] P3blk_v,
    input  logic [4:0] P4blk_v,
    input  logic [4:0] P1blk_h,
    input  logic [4:0] P2blk_h,
    input  logic [4:0] P3blk_h,
    input  logic [4:0] P4blk_h,
    input  logic [2:0] volatile_blk_color,
    output logic       movement_commit,
    output logic       movement_declined,
    output logic       movement_steal,
    input  logic [4:0] rd_v,
    input  logic [4:0] rd_h,
    output logic [2:0] rd_color,
    output logic [7:0] lines_cleared,
    output logic       game_over,
    output logic       busy
);

    localparam logic [4:0] c_rows    = 5'(ROWS);
    localparam logic [4:0] c_cols    = 5'(COLS);
    localparam logic [4:0] c_go_row  = 5'(GAMEOVER_ROW);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        CHECK    = 4'd1,
        COMMIT   = 4'd2,
        WAIT_LOW = 4'd3,
        DECLINE  = 4'd4,
        LAND     = 4'd5,
        CLEAR    = 4'd6,
        STEAL    = 4'd7
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic       hit_q, hit_d;
    logic [4:0] row_q, row_d;
    logic [4:0] lv_q [4];
    logic [4:0] lh_q [4];
    logic       intent_q;
    logic [2:0] color_q;
    logic [2:0] board_q [ROWS][COLS];
    logic       commit_q, declined_q, steal_q;
    logic [2:0] rd_color_q;
    logic [7:0] lines_q;
    logic       game_over_q;

    logic [4:0] w_v, w_h, w_th;
    logic [2:0] w_cell;
    logic [2:0] w_rd_cell;
    logic       w_collide;
    logic       w_land_ok;
    logic       w_land_go;
    logic       w_row_full;

    assign w_v  = lv_q[idx_q];
    assign w_h  = lh_q[idx_q];
    // Landing writes one row above the rejected proposal: the last committed spot.
    assign w_th = w_h - 5'd1;

    always_comb begin
        w_cell    = 3'd0;
        w_rd_cell = 3'd0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (w_h == 5'(r) && w_v == 5'(c))
                    w_cell = board_q[r][c];
                if (rd_h == 5'(r) && rd_v == 5'(c))
                    w_rd_cell = board_q[r][c];
            end
        end
    end

    always_comb begin
        w_row_full = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_q == 5'(r)) begin
                w_row_full = 1'b1;
                for (int c = 0; c < COLS; c++) begin
                    if (board_q[r][c] == 3'd0)
                        w_row_full = 1'b0;
                end
            end
        end
    end

    assign w_collide = (w_v >= c_cols) || (w_h >= c_rows) || (w_cell != 3'd0);
    assign w_land_ok = (w_h != 5'd0) && (w_v < c_cols) && (w_th < c_rows);
    assign w_land_go = (w_h != 5'd0) && (w_th <= c_go_row);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hit_d   = hit_q;
        row_d   = row_q;
        case (state_q)
            IDLE: begin
                if (movement_request) begin
                    state_d = CHECK;
                    idx_d   = 2'd0;
                    hit_d   = 1'b0;
                end
            end
            CHECK: begin
                hit_d = hit_q | w_collide;
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    if (game_over_q)
                        state_d = DECLINE;
                    else if (!hit_d)
                        state_d = COMMIT;
                    else if (intent_q)
                        state_d = DECLINE;
                    else
                        state_d = LAND;
                end
            end
            COMMIT:   state_d = WAIT_LOW;
            WAIT_LOW: if (!movement_request) state_d = IDLE;
            DECLINE:  if (!movement_request) state_d = IDLE;
            STEAL:    if (!movement_request) state_d = IDLE;
            LAND: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = CLEAR;
                    row_d   = c_rows - 5'd1;
                end
            end
            CLEAR: begin
                // A full row collapses in place; the cursor stays to re-test the new contents.
                if (!w_row_full) begin
                    if (row_q == 5'd0)
                        state_d = STEAL;
                    else
                        row_d = row_q - 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            hit_q       <= 1'b0;
            row_q       <= 5'd0;
            intent_q    <= 1'b0;
            color_q     <= 3'd0;
            commit_q    <= 1'b0;
            declined_q  <= 1'b0;
            steal_q     <= 1'b0;
            rd_color_q  <= 3'd0;
            lines_q     <= 8'd0;
            game_over_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                lv_q[i] <= 5'd0;
                lh_q[i] <= 5'd0;
            end
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    board_q[r][c] <= 3'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            hit_q      <= hit_d;
            row_q      <= row_d;
            commit_q   <= (state_d == COMMIT);
            declined_q <= (state_d == DECLINE);
            steal_q    <= (state_d == STEAL);
            rd_color_q <= w_rd_cell;

            if (state_q == IDLE && movement_request) begin
                lv_q[0]  <= P1blk_v;
                lv_q[1]  <= P2blk_v;
                lv_q[2]  <= P3blk_v;
                lv_q[3]  <= P4blk_v;
                lh_q[0]  <= P1blk_h;
                lh_q[1]  <= P2blk_h;
                lh_q[2]  <= P3blk_h;
                lh_q[3]  <= P4blk_h;
                intent_q <= movement_intent;
                color_q  <= volatile_blk_color;
            end

            if (state_q == LAND) begin
                if (w_land_ok) begin
                    for (int r = 0; r < ROWS; r++)
                        for (int c = 0; c < COLS; c++)
                            if (w_th == 5'(r) && w_v == 5'(c))
                                board_q[r][c] <= color_q;
                end
                if (w_land_go)
                    game_over_q <= 1'b1;
            end

            if (state_q == CLEAR && w_row_full) begin
                for (int r = 1; r < ROWS; r++)
                    if (5'(r) <= row_q)
                        for (int c = 0; c < COLS; c++)
                            board_q[r][c] <= board_q[r-1][c];
                for (int c = 0; c < COLS; c++)
                    board_q[0][c] <= 3'd0;
                lines_q <= lines_q + 8'd1;
            end
        end
    end

    assign movement_commit   = commit_q;
    assign movement_declined = declined_q;
    assign movement_steal    = steal_q;
    assign rd_color          = rd_color_q;
    assign lines_cleared     = lines_q;
    assign game_over         = game_over_q;
    assign busy              = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_movement_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_movement_arbiter - directed scoreboard bench for movement_arbiter
// Rev    : 1.0
// ============================================================================
module tb_movement_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       movement_request, movement_intent;
    logic [4:0] P1blk_v, P2blk_v, P3blk_v, P4blk_v;
    logic [4:0] P1blk_h, P2blk_h, P3blk_h, P4blk_h;
    logic [2:0] volatile_blk_color;
    logic       movement_commit, movement_declined, movement_steal;
    logic [4:0] rd_v, rd_h;
    logic [2:0] rd_color;
    logic [7:0] lines_cleared;
    logic       game_over, busy;

    movement_arbiter #(.ROWS(20), .COLS(10), .GAMEOVER_ROW(1)) dut (
        .clk               (clk),
        .reset             (reset),
        .movement_request  (movement_request),
        .movement_intent   (movement_intent),
        .P1blk_v           (P1blk_v),
        .P2blk_v           (P2blk_v),
        .P3blk_v           (P3blk_v),
        .P4blk_v           (P4blk_v),
        .P1blk_h           (P1blk_h),
        .P2blk_h           (P2blk_h),
        .P3blk_h           (P3blk_h),
        .P4blk_h           (P4blk_h),
        .volatile_blk_color(volatile_blk_color),
        .movement_commit   (movement_commit),
        .movement_declined (movement_declined),
        .movement_steal    (movement_steal),
        .rd_v              (rd_v),
        .rd_h              (rd_h),
        .rd_color          (rd_color),
        .lines_cleared     (lines_cleared),
        .game_over         (game_over),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Response kinds: 0 none, 1 commit, 2 declined, 3 steal
    int exp_kind_q[$];
    int exp_lat_q[$];

    typedef struct {
        int v;
        int h;
        int e;
    } rd_t;
    rd_t rdq[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic drive_req(input int v1, input int h1, input int v2, input int h2,
                             input int v3, input int h3, input int v4, input int h4,
                             input logic intent, input logic [2:0] color,
                             input int ek, input int el);
        exp_kind_q.push_back(ek);
        exp_lat_q.push_back(el);
        P1blk_v = 5'(v1); P1blk_h = 5'(h1);
        P2blk_v = 5'(v2); P2blk_h = 5'(h2);
        P3blk_v = 5'(v3); P3blk_h = 5'(h3);
        P4blk_v = 5'(v4); P4blk_h = 5'(h4);
        movement_intent    = intent;
        volatile_blk_color = color;
        movement_request   = 1'b1;
    endtask

    task automatic wait_resp(input int budget, output int kind, output int cyc);
        kind = 0;
        cyc  = 0;
        while (kind == 0 && cyc < budget) begin
            step();
            cyc++;
            if (movement_commit)        kind = 1;
            else if (movement_declined) kind = 2;
            else if (movement_steal)    kind = 3;
        end
    endtask

    task automatic collect(input string tag, input int hold);
        int kind, cyc, ek, el;
        ek = exp_kind_q.pop_front();
        el = exp_lat_q.pop_front();
        wait_resp(60, kind, cyc);
        chk({tag, "_kind"}, 32'(kind), 32'(ek));
        chk({tag, "_lat"}, 32'(cyc), 32'(el));
        if (kind != 0)
            chk({tag, "_onehot"},
                32'(movement_commit) + 32'(movement_declined) + 32'(movement_steal), 32'd1);
        if (ek == 1) begin
            step();
            chk({tag, "_pulse"}, 32'(movement_commit), 32'd0);
        end else begin
            for (int i = 0; i < hold; i++) begin
                step();
                chk({tag, "_hold"}, 32'(ek == 2 ? movement_declined : movement_steal), 32'd1);
            end
        end
        movement_request = 1'b0;
        step();
        chk({tag, "_drop"}, 32'({movement_commit, movement_declined, movement_steal}), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic push_rd(input int av, input int ah, input int ae);
        rd_t r;
        r.v = av;
        r.h = ah;
        r.e = ae;
        rdq.push_back(r);
    endtask

    task automatic drain_rd(input string tag);
        rd_t r;
        while (rdq.size() > 0) begin
            r = rdq.pop_front();
            rd_v = 5'(r.v);
            rd_h = 5'(r.h);
            step();
            chk($sformatf("%s_rd(%0d,%0d)", tag, r.v, r.h), 32'(rd_color), 32'(r.e));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind, cyc;
        reset = 1'b1;
        movement_request = 1'b0; movement_intent = 1'b0;
        P1blk_v = '0; P2blk_v = '0; P3blk_v = '0; P4blk_v = '0;
        P1blk_h = '0; P2blk_h = '0; P3blk_h = '0; P4blk_h = '0;
        volatile_blk_color = 3'd0; rd_v = '0; rd_h = '0;
        repeat (3) step();
        chk("rst_commit", 32'(movement_commit), 32'd0);
        chk("rst_declined", 32'(movement_declined), 32'd0);
        chk("rst_steal", 32'(movement_steal), 32'd0);
        chk("rst_rd", 32'(rd_color), 32'd0);
        chk("rst_lines", 32'(lines_cleared), 32'd0);
        chk("rst_gameover", 32'(game_over), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        step();

        // Free move on an empty board: one commit pulse, board untouched.
        drive_req(5, 1, 6, 1, 5, 2, 6, 2, 1'b1, 3'd2, 1, 5);
        collect("commit", 0);
        push_rd(5, 1, 0); push_rd(6, 1, 0); push_rd(5, 2, 0); push_rd(6, 2, 0);
        drain_rd("commit");

        // Left wall wrap (v=31) declines and holds while request stays high.
        drive_req(31, 1, 6, 1, 5, 2, 6, 2, 1'b1, 3'd2, 2, 5);
        collect("wall", 3);
        push_rd(6, 1, 0); push_rd(5, 2, 0);
        drain_rd("wall");

        // Vertical I falls past the floor: lands one row up.
        drive_req(4, 17, 4, 18, 4, 19, 4, 20, 1'b0, 3'd3, 3, 29);
        collect("ipiece", 1);
        push_rd(4, 16, 3); push_rd(4, 17, 3); push_rd(4, 18, 3); push_rd(4, 19, 3);
        push_rd(4, 15, 0); push_rd(4, 20, 0);
        drain_rd("ipiece");

        // Fill row 19 except col 9, then complete it with a block on row 18.
        drive_req(0, 20, 1, 20, 2, 20, 3, 20, 1'b0, 3'd1, 3, 29);
        collect("fillA", 1);
        drive_req(5, 20, 6, 20, 7, 20, 8, 20, 1'b0, 3'd2, 3, 29);
        collect("fillB", 1);
        push_rd(0, 19, 1); push_rd(8, 19, 2); push_rd(9, 19, 0);
        drain_rd("fill");
        drive_req(9, 20, 3, 19, 9, 20, 3, 19, 1'b0, 3'd5, 3, 30);
        collect("clear1", 1);
        chk("clear1_lines", 32'(lines_cleared), 32'd1);
        chk("clear1_go", 32'(game_over), 32'd0);
        push_rd(3, 19, 5); push_rd(4, 19, 3); push_rd(9, 19, 0); push_rd(0, 19, 0);
        push_rd(8, 19, 0); push_rd(3, 18, 0); push_rd(4, 18, 3); push_rd(4, 17, 3);
        push_rd(4, 16, 0);
        drain_rd("clear1");

        // Landing with a cell on row 1 trips game_over.
        drive_req(7, 2, 8, 2, 7, 3, 8, 31, 1'b0, 3'd6, 3, 29);
        collect("gameover", 1);
        chk("gameover_flag", 32'(game_over), 32'd1);
        push_rd(7, 1, 6); push_rd(8, 1, 6); push_rd(7, 2, 6); push_rd(8, 2, 0);
        drain_rd("gameover");

        // After game over every request declines, whatever the intent.
        drive_req(0, 5, 1, 5, 0, 6, 1, 6, 1'b1, 3'd4, 2, 5);
        collect("go_move", 1);
        drive_req(0, 5, 1, 5, 0, 20, 1, 6, 1'b0, 3'd4, 2, 5);
        collect("go_fall", 1);
        push_rd(0, 19, 0); push_rd(0, 5, 0);
        drain_rd("go_fall");

        // Request withdrawn mid-check is still answered, then drops one cycle later.
        drive_req(0, 5, 1, 5, 0, 6, 1, 6, 1'b1, 3'd4, 2, 3);
        step(); step();
        movement_request = 1'b0;
        wait_resp(20, kind, cyc);
        chk("midchk_kind", 32'(kind), 32'(exp_kind_q.pop_front()));
        chk("midchk_lat", 32'(cyc), 32'(exp_lat_q.pop_front()));
        step();
        chk("midchk_drop", 32'(movement_declined), 32'd0);
        chk("midchk_idle", 32'(busy), 32'd0);

        // Reset clears game over; then abort a landing mid-clear.
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst2_gameover", 32'(game_over), 32'd0);
        chk("rst2_lines", 32'(lines_cleared), 32'd0);
        rd_v = 5'd0; rd_h = 5'd19;
        drive_req(0, 20, 1, 20, 2, 20, 3, 20, 1'b0, 3'd4, 3, 29);
        void'(exp_kind_q.pop_front());
        void'(exp_lat_q.pop_front());
        repeat (12) step();
        chk("midclr_busy", 32'(busy), 32'd1);
        chk("midclr_written", 32'(rd_color), 32'd4);
        reset = 1'b1;
        movement_request = 1'b0;
        step();
        reset = 1'b0;
        chk("abort_commit", 32'(movement_commit), 32'd0);
        chk("abort_declined", 32'(movement_declined), 32'd0);
        chk("abort_steal", 32'(movement_steal), 32'd0);
        chk("abort_rd", 32'(rd_color), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_gameover", 32'(game_over), 32'd0);
        push_rd(0, 19, 0); push_rd(1, 19, 0); push_rd(2, 19, 0); push_rd(3, 19, 0);
        push_rd(7, 1, 0); push_rd(4, 18, 0);
        drain_rd("abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/movement_arbiter.md
Name: movement_arbiter

Overview:
- Responder side of the piece-movement handshake.
- The volatile piece store proposes a new position for its four blocks (P1..P4, v = column, h = row, h grows downward) by raising movement_request.
- This block checks the proposal against board bounds and the static cell board, then answers with commit, decline or steal.
- On steal (the piece landed) it freezes the piece into the board, clears full rows, and serves a registered read port to the renderer.

Parameters:
- ROWS, 20, board height in cells (h valid 0..ROWS-1)
- COLS, 10, board width in cells (v valid 0..COLS-1)
- GAMEOVER_ROW, 1, a landed cell with row <= this value sets game_over

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- movement_request  in  1  proposal valid (level)
- movement_intent  in  1  0 = natural fall (h+1), 1 = player move/rotate
- P1blk_v,P2blk_v,P3blk_v,P4blk_v  in  5 each  proposed block columns
- P1blk_h,P2blk_h,P3blk_h,P4blk_h  in  5 each  proposed block rows
- volatile_blk_color  in  3  colour of the moving piece (nonzero)
- movement_commit  out  1  single-cycle accept pulse
- movement_declined  out  1  reject level, player move
- movement_steal  out  1  landing level, piece frozen
- rd_v  in  5  renderer read column
- rd_h  in  5  renderer read row
- rd_color  out  3  cell colour, 0 = empty, valid 1 cycle after address
- lines_cleared  out  8  count of cleared rows, wraps 255->0
- game_over  out  1  sticky overflow flag
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (sync, active-high):
  - all board cells 0; state IDLE
  - commit/declined/steal 0; rd_color 0; lines_cleared 0; game_over 0
- Storage: ROWS x COLS cells, 3 bits each. Cell occupied iff colour != 0.
- Read port: rd_color <= cell[rd_h][rd_v] every cycle. Out-of-range address returns 0.
- FSM states: IDLE, CHECK, COMMIT, WAIT_LOW, DECLINE, LAND, CLEAR, STEAL.
- IDLE:
  - On movement_request=1, latch all 8 coordinates, intent and colour, then go to CHECK with idx=0.
  - Inputs are not re-sampled until the block returns to IDLE.
- CHECK (4 cycles, idx 0..3): block idx collides if v >= COLS, or h >= ROWS, or its cell is occupied. Collisions accumulate into a hit flag.
  - 5-bit wrap (e.g. v=0-1=31) is out of bounds by the rule above.
- After idx 3:
  - game_over=1 -> DECLINE, whatever the intent.
  - no hit -> COMMIT.
  - hit and intent=1 -> DECLINE.
  - hit and intent=0 -> LAND.
- COMMIT: movement_commit=1 for exactly one cycle, then WAIT_LOW.
- WAIT_LOW: stay until movement_request=0, then IDLE.
- DECLINE: hold movement_declined=1 while movement_request=1. In the first cycle request is 0, drop declined (registered) and go to IDLE.
- LAND (4 cycles, one block per cycle):
  - Write the latched colour to cell[h-1][v]. This is the piece's last committed position.
  - Skip the write if h==0 or the target is out of bounds.
  - If h-1 <= GAMEOVER_ROW, set game_over.
- CLEAR:
  - Row cursor r starts at ROWS-1.
  - If row r is full: in one cycle every row k<=r takes row k-1, row 0 becomes empty, lines_cleared increments, and r does not change.
  - Otherwise r decrements.
  - When r passes 0, go to STEAL.
  - Four stacked full rows take 4 clear cycles plus ROWS scan cycles.
- STEAL: same hold/drop rule as DECLINE, using movement_steal. The board is final before steal asserts, so a newly spawned piece always checks against the updated board.
- Outputs are never asserted together.
- A request that drops mid-CHECK is still answered. The DECLINE/STEAL level then drops one cycle after the outcome is reached.
- Reset mid-operation aborts immediately to the reset state, including mid-LAND and mid-CLEAR.

Test Plan:
- Empty board, intent=1, blocks (5,1),(6,1),(5,2),(6,2) -> movement_commit is a single pulse 5 cycles after request rises. Board unchanged.
- Intent=1, P1blk_v=31 (left wall wrap) -> movement_declined holds until request falls, then drops the next cycle. Board unchanged.
- Intent=0, colour 3'b011, vertical I at v=4, h=17..20 (h=20 out of bounds) -> steal. rd_color at (4,16..19) = 3. Cell (4,20) untouched.
- Row 19 pre-filled in cols 0..8; land a piece completing col 9, plus one block at (3,18) -> lines_cleared=1. Row 19 col 3 reads the former row 18 block. Row 18 reads as empty where row 17 was empty.
- Land a piece with one cell at row 1 -> game_over=1. The next request (either intent) gets declined, never commit.
- Assert reset during CLEAR -> next cycle all outputs are 0 and every rd_color read returns 0.
